// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load/store definitions for the load/store unit.
// Holds the RV32I load/store funct3 codes, the LSU state type and the
// alignment helper used when a request is accepted.
package lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    // Byte ops never straddle; halfwords need addr[0]==0; everything else,
    // including unknown funct3 codes, is treated as a word.
    function automatic logic lsu_is_aligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            FUNCT3_LB, FUNCT3_LBU: ok = 1'b1;
            FUNCT3_LH, FUNCT3_LHU: ok = !addr_lo[0];
            default:               ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu.sv
// lsu: load/store unit driving a byte-addressable memory port.
// Ports: req_* (valid/ready request from the memory stage), rsp_* (one-cycle
// completion pulse with load data and split flag), mem_* (memory port, with
// combinational read data on mem_rdata_i). clk/rst: synchronous active-high.
// Misaligned halfword/word accesses are split into byte beats and rebuilt.
module lsu
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [2:0]        req_funct3_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_misaligned_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        f3_q;
    logic [1:0]        last_q;
    logic [1:0]        beat_q;
    logic [DWIDTH-1:0] buf_q;

    // Index of the final beat for an incoming request (beats - 1).
    logic              in_aligned;
    logic [1:0]        in_last;

    // Drive values for the beat that will be presented after the next edge:
    // beat 0 of a new request from IDLE, otherwise beat_q+1.
    logic              src_we;
    logic [AWIDTH-1:0] src_addr;
    logic [DWIDTH-1:0] src_wdata;
    logic [2:0]        src_f3;
    logic              src_mis;
    logic [1:0]        src_k;
    logic [DWIDTH-1:0] src_shift;
    logic [AWIDTH-1:0] addr_d;
    logic [DWIDTH-1:0] wdata_d;
    logic [2:0]        f3_d;

    logic [DWIDTH-1:0] buf_d;
    logic [DWIDTH-1:0] rdata_d;

    always_comb begin
        in_aligned = lsu_is_aligned(req_funct3_i, req_addr_i[1:0]);
        in_last    = 2'd0;
        if (!in_aligned) begin
            if (req_funct3_i[1:0] == 2'b01) in_last = 2'd1;
            else                            in_last = 2'd3;
        end
    end

    always_comb begin
        if (state_q == IDLE) begin
            src_we    = req_we_i;
            src_addr  = req_addr_i;
            src_wdata = req_wdata_i;
            src_f3    = req_funct3_i;
            src_mis   = !in_aligned;
            src_k     = 2'd0;
        end else begin
            src_we    = we_q;
            src_addr  = addr_q;
            src_wdata = wdata_q;
            src_f3    = f3_q;
            src_mis   = (last_q != 2'd0);
            src_k     = beat_q + 2'd1;
        end
        src_shift = src_wdata >> {src_k, 3'b000};
        if (src_mis) begin
            addr_d  = src_addr + AWIDTH'(src_k);
            wdata_d = {{(DWIDTH-8){1'b0}}, src_shift[7:0]};
            f3_d    = src_we ? FUNCT3_SB : FUNCT3_LBU;
        end else begin
            addr_d  = src_addr;
            wdata_d = src_wdata;
            f3_d    = src_f3;
        end
    end

    // Aligned loads take the already-extended word; split loads collect
    // one byte per beat, little-endian, then get extended here.
    always_comb begin
        buf_d = buf_q;
        if (last_q == 2'd0) buf_d = mem_rdata_i;
        else buf_d[{beat_q, 3'b000} +: 8] = mem_rdata_i[7:0];
        rdata_d = buf_d;
        if (last_q != 2'd0) begin
            if (f3_q == FUNCT3_LH)
                rdata_d = {{(DWIDTH-16){buf_d[15]}}, buf_d[15:0]};
            else if (f3_q == FUNCT3_LHU)
                rdata_d = {{(DWIDTH-16){1'b0}}, buf_d[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            f3_q             <= 3'b000;
            last_q           <= 2'd0;
            beat_q           <= 2'd0;
            buf_q            <= '0;
            req_ready_o      <= 1'b1;
            rsp_valid_o      <= 1'b0;
            rsp_rdata_o      <= '0;
            rsp_misaligned_o <= 1'b0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
            mem_read_en_o    <= 1'b0;
            mem_write_en_o   <= 1'b0;
            mem_funct3_o     <= 3'b000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        state_q        <= ACCESS;
                        we_q           <= req_we_i;
                        addr_q         <= req_addr_i;
                        wdata_q        <= req_wdata_i;
                        f3_q           <= req_funct3_i;
                        last_q         <= in_last;
                        beat_q         <= 2'd0;
                        buf_q          <= '0;
                        req_ready_o    <= 1'b0;
                        mem_addr_o     <= addr_d;
                        mem_wdata_o    <= wdata_d;
                        mem_funct3_o   <= f3_d;
                        mem_read_en_o  <= !req_we_i;
                        mem_write_en_o <= req_we_i;
                    end
                end
                ACCESS: begin
                    if (!we_q) buf_q <= buf_d;
                    if (beat_q == last_q) begin
                        state_q          <= RESP;
                        mem_addr_o       <= '0;
                        mem_wdata_o      <= '0;
                        mem_funct3_o     <= 3'b000;
                        mem_read_en_o    <= 1'b0;
                        mem_write_en_o   <= 1'b0;
                        rsp_valid_o      <= 1'b1;
                        rsp_rdata_o      <= we_q ? '0 : rdata_d;
                        rsp_misaligned_o <= (last_q != 2'd0);
                    end else begin
                        beat_q       <= beat_q + 2'd1;
                        mem_addr_o   <= addr_d;
                        mem_wdata_o  <= wdata_d;
                        mem_funct3_o <= f3_d;
                    end
                end
                RESP: begin
                    state_q          <= IDLE;
                    req_ready_o      <= 1'b1;
                    rsp_valid_o      <= 1'b0;
                    rsp_rdata_o      <= '0;
                    rsp_misaligned_o <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a 256-byte memory model on the
// memory port; checks data, latency, beat traffic, reset abort, handshake.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_misaligned_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [2:0]  mem_funct3_o;
    logic [31:0] mem_rdata_i;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;

    logic [31:0] wl_addr [$];
    logic [31:0] wl_data [$];
    logic [2:0]  wl_f3   [$];

    lsu #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_we_i         (req_we_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_funct3_i     (req_funct3_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_misaligned_o (rsp_misaligned_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_read_en_o    (mem_read_en_o),
        .mem_write_en_o   (mem_write_en_o),
        .mem_funct3_o     (mem_funct3_o),
        .mem_rdata_i      (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational extended read, write at rising edge.
    always_comb begin
        a0 = mem_addr_o[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        case (mem_funct3_o)
            3'b000:  mem_rdata_i = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata_i = {{16{b1[7]}}, b1, b0};
            3'b100:  mem_rdata_i = {24'h0, b0};
            3'b101:  mem_rdata_i = {16'h0, b1, b0};
            default: mem_rdata_i = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write_en_o) begin
            wl_addr.push_back(mem_addr_o);
            wl_data.push_back(mem_wdata_o);
            wl_f3.push_back(mem_funct3_o);
            mem[a0] <= mem_wdata_o[7:0];
            if (mem_funct3_o[1:0] != 2'b00) mem[a1] <= mem_wdata_o[15:8];
            if (mem_funct3_o[1:0] == 2'b10) begin
                mem[a2] <= mem_wdata_o[23:16];
                mem[a3] <= mem_wdata_o[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge; lat counts cycles from the accept
    // cycle (cycle 0) to the cycle rsp_valid_o is seen; 0 means timeout.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          output logic [31:0] rd, output logic mis,
                          output int lat);
        @(negedge clk);
        wl_addr.delete();
        wl_data.delete();
        wl_f3.delete();
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        req_funct3_i = f3;
        rd  = '0;
        mis = 1'b0;
        lat = 0;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat = i;
                rd  = rsp_rdata_o;
                mis = rsp_misaligned_o;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          seen;

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_funct3_i = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_rvalid", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'h0);
        chk("rst_mis", {31'b0, rsp_misaligned_o}, 32'd0);
        chk("rst_mem", {mem_addr_o[15:0], mem_wdata_o[7:0], 3'b0,
            mem_read_en_o, mem_write_en_o, mem_funct3_o}, 32'h0);

        // Aligned word store and load.
        do_req(1'b1, 32'h0100_0010, 32'h1122_3344, 3'b010, rd, mis, lat);
        chk("sw_lat", lat, 2);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_mis", {31'b0, mis}, 32'd0);
        chk("sw_beats", wl_addr.size(), 1);
        if (wl_addr.size() == 1) begin
            chk("sw_addr", wl_addr[0], 32'h0100_0010);
            chk("sw_f3", {29'b0, wl_f3[0]}, 32'd2);
            chk("sw_data", wl_data[0], 32'h1122_3344);
        end
        do_req(1'b0, 32'h0100_0010, 32'h0, 3'b010, rd, mis, lat);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rd, 32'h1122_3344);
        chk("lw_mis", {31'b0, mis}, 32'd0);

        // Misaligned word store: four SB beats, little-endian.
        do_req(1'b1, 32'h0100_0021, 32'hAABB_CCDD, 3'b010, rd, mis, lat);
        chk("msw_lat", lat, 5);
        chk("msw_mis", {31'b0, mis}, 32'd1);
        chk("msw_beats", wl_addr.size(), 4);
        if (wl_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("msw_addr", wl_addr[k], 32'h0100_0021 + k);
                chk("msw_f3", {29'b0, wl_f3[k]}, 32'd0);
            end
            chk("msw_d0", wl_data[0], 32'h0000_00DD);
            chk("msw_d1", wl_data[1], 32'h0000_00CC);
            chk("msw_d2", wl_data[2], 32'h0000_00BB);
            chk("msw_d3", wl_data[3], 32'h0000_00AA);
        end
        do_req(1'b0, 32'h0100_0021, 32'h0, 3'b010, rd, mis, lat);
        chk("mlw_lat", lat, 5);
        chk("mlw_rdata", rd, 32'hAABB_CCDD);
        chk("mlw_mis", {31'b0, mis}, 32'd1);

        // Misaligned halfword sign/zero extension.
        do_req(1'b1, 32'h0100_0031, 32'h0000_0034, 3'b000, rd, mis, lat);
        chk("sb31_lat", lat, 2);
        do_req(1'b1, 32'h0100_0032, 32'h0000_0092, 3'b000, rd, mis, lat);
        do_req(1'b0, 32'h0100_0031, 32'h0, 3'b001, rd, mis, lat);
        chk("lh_lat", lat, 3);
        chk("lh_rdata", rd, 32'hFFFF_9234);
        chk("lh_mis", {31'b0, mis}, 32'd1);
        do_req(1'b0, 32'h0100_0031, 32'h0, 3'b101, rd, mis, lat);
        chk("lhu_lat", lat, 3);
        chk("lhu_rdata", rd, 32'h0000_9234);

        // Byte extension, aligned.
        do_req(1'b1, 32'h0100_0040, 32'h1234_5680, 3'b000, rd, mis, lat);
        chk("sb40_mem", {24'b0, mem[8'h40]}, 32'h80);
        chk("sb40_next", {24'b0, mem[8'h41]}, 32'h00);
        do_req(1'b0, 32'h0100_0040, 32'h0, 3'b000, rd, mis, lat);
        chk("lb_lat", lat, 2);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        do_req(1'b0, 32'h0100_0040, 32'h0, 3'b100, rd, mis, lat);
        chk("lbu_lat", lat, 2);
        chk("lbu_rdata", rd, 32'h0000_0080);
        chk("lbu_mis", {31'b0, mis}, 32'd0);

        // Reset during beat 1 of a misaligned word store.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_addr_i   = 32'h0100_0051;
        req_wdata_i  = 32'hAABB_CCDD;
        req_funct3_i = 3'b010;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_b0_addr", mem_addr_o, 32'h0100_0051);
        @(negedge clk);
        chk("abort_b1_addr", mem_addr_o, 32'h0100_0052);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'b0, req_ready_o}, 32'd1);
        chk("abort_we", {31'b0, mem_write_en_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid_o) seen++;
            @(negedge clk);
        end
        chk("abort_norsp", seen, 0);
        chk("abort_m51", {24'b0, mem[8'h51]}, 32'hDD);
        chk("abort_m52", {24'b0, mem[8'h52]}, 32'hCC);
        chk("abort_m53", {24'b0, mem[8'h53]}, 32'h00);
        chk("abort_m54", {24'b0, mem[8'h54]}, 32'h00);

        // Handshake: valid held across two back-to-back requests.
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_addr_i   = 32'h0100_0010;
        req_funct3_i = 3'b010;
        chk("hs_ready_c0", {31'b0, req_ready_o}, 32'd1);
        @(negedge clk);
        chk("hs_ready_c1", {31'b0, req_ready_o}, 32'd0);
        chk("hs_addr_c1", mem_addr_o, 32'h0100_0010);
        req_addr_i   = 32'h0100_0040;
        req_funct3_i = 3'b100;
        @(negedge clk);
        chk("hs_ready_c2", {31'b0, req_ready_o}, 32'd0);
        chk("hs_rvalid_c2", {31'b0, rsp_valid_o}, 32'd1);
        chk("hs_rdata_c2", rsp_rdata_o, 32'h1122_3344);
        chk("hs_ren_c2", {31'b0, mem_read_en_o}, 32'd0);
        @(negedge clk);
        chk("hs_ready_c3", {31'b0, req_ready_o}, 32'd1);
        chk("hs_ren_c3", {31'b0, mem_read_en_o}, 32'd0);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("hs_ready_c4", {31'b0, req_ready_o}, 32'd0);
        chk("hs_addr_c4", mem_addr_o, 32'h0100_0040);
        chk("hs_f3_c4", {29'b0, mem_funct3_o}, 32'd4);
        @(negedge clk);
        chk("hs_rvalid_c5", {31'b0, rsp_valid_o}, 32'd1);
        chk("hs_rdata_c5", rsp_rdata_o, 32'h0000_0080);
        @(negedge clk);
        chk("hs_ready_c6", {31'b0, req_ready_o}, 32'd1);
        chk("hs_rvalid_c6", {31'b0, rsp_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the byte-addressable data `memory`. It accepts one load or store at a time from the core's memory stage over a valid/ready handshake. It drives the `memory` port (`addr_i`/`data_i`/`read_en_i`/`write_en_i`/`funct3_i`, read data back on `data_o`). It returns a one-cycle response carrying the load result. Naturally aligned accesses take one memory beat. Misaligned halfword/word accesses are split into sequential byte beats and reassembled, so `memory` only ever sees aligned or byte traffic.

## Interface
Clocking and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width (logic fixed at 4 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept (high only in IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  AWIDTH  byte address
- req_wdata_i  in  DWIDTH  store data (low bytes used for SB/SH)
- req_funct3_i  in  3  RV32I load/store funct3
- rsp_valid_o  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata_o  out  DWIDTH  extended load result; 0 for stores
- rsp_misaligned_o  out  1  request was split (valid with rsp_valid_o)
- mem_addr_o  out  AWIDTH  to memory addr_i
- mem_wdata_o  out  DWIDTH  to memory data_i
- mem_read_en_o  out  1  to memory read_en_i
- mem_write_en_o  out  1  to memory write_en_i
- mem_funct3_o  out  3  to memory funct3_i
- mem_rdata_i  in  DWIDTH  from memory data_o (combinational)

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i & req_ready_o, latch we/addr/wdata/funct3.
  - Compute `beats` and clear the beat counter, then go to ACCESS.
- **Alignment**
  - Byte ops (LB/LBU/SB) are always aligned.
  - Halfword ops (LH/LHU/SH) are aligned when addr[0]==0.
  - All other ops, including undefined funct3 values treated as word, are aligned when addr[1:0]==0.
  - Aligned: beats=1. Misaligned: beats=2 (halfword) or 4 (word).
- **ACCESS**, one beat per cycle, beat k:
  - Aligned: mem_addr_o=addr, mem_funct3_o=latched funct3, mem_wdata_o=wdata.
  - Misaligned: mem_addr_o=addr+k (mod 2^AWIDTH), mem_funct3_o=LBU (load) or SB (store), mem_wdata_o={24'b0, wdata[8k+7:8k]}.
  - mem_read_en_o=!we, mem_write_en_o=we, both only in ACCESS.
  - Loads: aligned beats capture mem_rdata_i whole, since memory already extends. Misaligned beats capture mem_rdata_i[7:0] into buffer byte k (little-endian).
  - After the last beat go to RESP.
- **RESP**
  - rsp_valid_o=1.
  - rsp_rdata_o=buffer; for misaligned loads, sign-extend from bit 15 for LH, zero-extend for LHU, pass through for word.
  - rsp_misaligned_o=(beats>1).
  - Next state: IDLE.
- No response backpressure; the core must stall on !rsp_valid_o.
- No error reporting. Out-of-range handling belongs to memory (for example, a DEADBEEF read value is passed through unchanged).

## Timing
- Reset values: state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_misaligned_o=0, mem_* outputs 0, buffer 0.
- Request accepted at edge E0 gives ACCESS during E0–E(beats), then RESP for one cycle.
- Latency from accept to rsp_valid_o is beats+1 cycles: aligned 2, misaligned half 3, misaligned word 5.
- The next accept happens no earlier than the cycle after RESP.
- Stores commit at the rising edge ending each ACCESS beat.
- req_valid_i asserted outside IDLE is ignored; the requester must hold it until accepted.
- rst in any state returns to IDLE the next cycle.
  - Beats already written stay written (partial misaligned store).
  - No rsp_valid_o is produced for the aborted request.
- Address wrap: addr+k wraps mod 2^AWIDTH with no special handling.

## Structure
- The shared package holds:
  - the existing FUNCT3_* load/store constants (reused, not redefined);
  - `lsu_state_e` {IDLE, ACCESS, RESP};
  - a function `lsu_is_aligned(funct3, addr[1:0])`.
- Single module, no sub-modules.
- The beat counter is 2 bits.

## Test plan
- Aligned round trip: SW 0x11223344 @0x01000010, then LW @0x01000010.
  - One write beat with mem_funct3_o=SW.
  - rsp_rdata_o=0x11223344 two cycles after accept, rsp_misaligned_o=0.
- Misaligned word: SW 0xAABBCCDD @0x01000021.
  - Four SB beats to 0x…21..0x…24 carrying DD, CC, BB, AA.
  - LW @0x01000021 returns 0xAABBCCDD at latency 5 with rsp_misaligned_o=1.
- Misaligned halfword extension: bytes @0x01000031=0x34, @0x01000032=0x92.
  - LH @0x01000031 returns 0xFFFF9234.
  - LHU returns 0x00009234, each at latency 3.
- Byte extension: byte 0x80 @0x01000040.
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
  - Both aligned, latency 2.
- Reset mid-op: SW 0xAABBCCDD @0x01000051, rst asserted during beat 1.
  - Only 0x…51=DD and 0x…52=CC are written.
  - No rsp_valid_o; req_ready_o=1 the cycle after reset.
- Handshake: req_valid_i held high continuously over two requests.
  - Second request accepted only in the cycle after the first RESP.
  - req_ready_o=0 throughout ACCESS/RESP.
